mem_arbiter: RTL and testbench

Sequences all accesses to the shared dual-port block-RAM memory on behalf of three requesters: instruction fetch, the pipeline's data stage, and a program-loader burst engine. Port 1 (read-only) serves fetch. Port 2 (read/write) is arbitrated between the data stage and the loader, with a starvation guard. The block generates every memory strobe (enable, per-byte write enables, replicated byte write data) and returns read-valid pulses aligned to the memory's one-cycle synchronous read latency.

---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Sequences every access to the shared dual-port block RAM for three
//   requesters:
//     - port 1 (read-only): instruction fetch, served only while the loader is idle
//     - port 2 (read/write): the pipeline data stage and the program-loader
//       burst engine, with a starvation guard for the data stage
//   Grants and all m_* strobes are combinational in the request cycle. The
//   memory samples them on the next rising edge, so the read-valid pulses are
//   registered copies of the grants.
//
// Parameters
//   STARVE_MAX  consecutive loader writes tolerated while a data request
//               waits (must be >= 1)
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request and byte address
//   if_ack/if_rvalid/if_rdata      fetch grant, data valid, read data
//   d_req/d_we/d_byte              data request, write flag, byte-size flag
//   d_addr/d_wdata                 data byte address, write data
//   d_ack/d_rvalid/d_rdata         data grant, read valid, read data
//   ld_start/ld_base/ld_count      burst start, base byte address, word count
//   ld_wvalid/ld_wdata/ld_wready   loader write-data handshake
//   ld_busy/ld_done                burst in progress, completion pulse
//   m_addr1/m_addr2                memory port byte addresses
//   m_en/m_we_low/m_we_high        memory enable and byte write enables
//   m_data_in                      memory write data (port 2)
//   m_data1_out/m_data2_out        memory read data (port 1, port 2)
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  input  logic        ld_start,
  input  logic [15:0] ld_base,
  input  logic [15:0] ld_count,
  input  logic        ld_wvalid,
  input  logic [15:0] ld_wdata,
  output logic        ld_wready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [15:0] m_addr1,
  output logic [15:0] m_addr2,
  output logic        m_en,
  output logic        m_we_low,
  output logic        m_we_high,
  output logic [15:0] m_data_in,
  input  logic [15:0] m_data1_out,
  input  logic [15:0] m_data2_out
);

  localparam int STRK_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

  ld_state_t         state;
  logic [15:0]       ld_left;
  logic [15:0]       ld_baddr;
  logic [STRK_W-1:0] streak;
  logic              if_vld_p1;
  logic              d_vld_p1;

  logic in_idle;
  logic in_load;
  logic starve;
  logic ld_grant;
  logic d_grant;
  logic if_grant;

  // Byte writes put the low byte of the write data on both lanes; the byte
  // enables then pick which half of the word actually changes.
  function automatic logic [15:0] byte_lanes(input logic [15:0] w);
    return {w[7:0], w[7:0]};
  endfunction

  // Everything combinational is forced low while reset is held.
  always_comb begin
    in_idle  = rst_n && (state == IDLE);
    in_load  = rst_n && (state == LOAD);
    starve   = in_load && d_req && (streak >= STRK_W'(STARVE_MAX));
    ld_grant = in_load && ld_wvalid && !starve;
    // Data wins port 2 whenever the loader is not taking it this cycle.
    d_grant  = rst_n && d_req && !ld_grant;
    if_grant = in_idle && if_req;
  end

  always_comb begin
    m_addr2   = '0;
    m_data_in = '0;
    m_we_low  = 1'b0;
    m_we_high = 1'b0;
    if (ld_grant) begin
      m_addr2   = ld_baddr;
      m_data_in = ld_wdata;
      m_we_low  = 1'b1;
      m_we_high = 1'b1;
    end else if (d_grant) begin
      m_addr2 = d_addr;
      if (d_we) begin
        if (d_byte) begin
          m_data_in = byte_lanes(d_wdata);
          m_we_low  = !d_addr[0];
          m_we_high = d_addr[0];
        end else begin
          m_data_in = d_wdata;
          m_we_low  = 1'b1;
          m_we_high = 1'b1;
        end
      end
    end
  end

  assign m_addr1   = rst_n ? if_addr : '0;
  assign m_en      = if_grant || d_grant || ld_grant;
  assign if_ack    = if_grant;
  assign d_ack     = d_grant;
  assign ld_wready = ld_grant;
  assign if_rdata  = rst_n ? m_data1_out : '0;
  assign d_rdata   = rst_n ? m_data2_out : '0;
  assign if_rvalid = if_vld_p1;
  assign d_rvalid  = d_vld_p1;

  // ---- stage p1: read-valid, one cycle behind the grant (RAM read latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_vld_p1 <= 1'b0;
      d_vld_p1  <= 1'b0;
    end else begin
      if_vld_p1 <= if_grant;
      d_vld_p1  <= d_grant && !d_we;
    end
  end

  // Loader FSM with registered busy/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ld_left <= '0;
      ld_busy <= 1'b0;
      ld_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            ld_busy <= 1'b1;
            if (ld_count == 16'd0) begin
              state   <= DONE;
              ld_done <= 1'b1;
            end else begin
              state   <= LOAD;
              ld_left <= ld_count;
            end
          end
        end
        LOAD: begin
          if (ld_grant) begin
            ld_left <= ld_left - 16'd1;
            if (ld_left == 16'd1) begin
              state   <= DONE;
              ld_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          ld_busy <= 1'b0;
          ld_done <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ld_busy <= 1'b0;
          ld_done <= 1'b0;
        end
      endcase
    end
  end

  // Burst write pointer: a byte address kept word-aligned, stepping by one
  // word and wrapping naturally at 2^16.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && ld_start) begin
      ld_baddr <= ld_base & 16'hFFFE;
    end else if (ld_grant) begin
      ld_baddr <= ld_baddr + 16'd2;
    end
  end

  // Streak of loader writes made while the data stage was kept waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!d_req || d_grant) begin
      streak <= '0;
    end else if (ld_grant) begin
      streak <= streak + STRK_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ack, if_rvalid;
  logic [15:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0;
  logic [15:0] d_addr = '0, d_wdata = '0;
  logic        d_ack, d_rvalid;
  logic [15:0] d_rdata;
  logic        ld_start = 1'b0;
  logic [15:0] ld_base = '0, ld_count = '0;
  logic        ld_wvalid = 1'b0;
  logic [15:0] ld_wdata = '0;
  logic        ld_wready, ld_busy, ld_done;
  logic [15:0] m_addr1, m_addr2;
  logic        m_en, m_we_low, m_we_high;
  logic [15:0] m_data_in;
  logic [15:0] m_data1_out, m_data2_out;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
    .ld_wvalid(ld_wvalid), .ld_wdata(ld_wdata), .ld_wready(ld_wready),
    .ld_busy(ld_busy), .ld_done(ld_done),
    .m_addr1(m_addr1), .m_addr2(m_addr2), .m_en(m_en),
    .m_we_low(m_we_low), .m_we_high(m_we_high), .m_data_in(m_data_in),
    .m_data1_out(m_data1_out), .m_data2_out(m_data2_out)
  );

  // Dual-port synchronous RAM, read-before-write, preloaded with word i = 2i.
  logic [15:0] mem [0:32767];
  bit          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'(2 * i);
      mem_loaded <= 1'b1;
    end else if (m_en) begin
      m_data1_out <= mem[m_addr1[15:1]];
      m_data2_out <= mem[m_addr2[15:1]];
      if (m_we_low)  mem[m_addr2[15:1]][7:0]  <= m_data_in[7:0];
      if (m_we_high) mem[m_addr2[15:1]][15:8] <= m_data_in[15:8];
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the arbiter and the memory.
  logic [15:0] ref_mem [0:32767];
  bit          r_active   = 1'b0;  // burst has words outstanding
  bit          r_done_due = 1'b0;  // completion cycle in progress
  int          r_left     = 0;
  logic [15:0] r_ptr      = '0;
  int          r_streak   = 0;
  bit          e_if_rv = 1'b0, e_d_rv = 1'b0;
  logic [15:0] e_if_dat = '0, e_d_dat = '0;

  // One clock: check outputs at the falling edge, advance model at the rising edge.
  task automatic step();
    bit          x_if, x_d, x_ld, starve, idle, x_wl, x_wh;
    logic [15:0] x_addr2, x_din;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ctrl", {22'd0, if_ack, d_ack, ld_wready, m_en, m_we_low, m_we_high,
                       if_rvalid, d_rvalid, ld_busy, ld_done}, 32'd0);
      chk("rst_addr", {m_addr1, m_addr2}, 32'd0);
      chk("rst_data", {m_data_in, if_rdata}, 32'd0);
      chk("rst_drdata", d_rdata, 32'd0);
      @(posedge clk);
      r_active = 1'b0; r_done_due = 1'b0; r_streak = 0;
      e_if_rv = 1'b0; e_d_rv = 1'b0;
    end else begin
      idle   = !r_active && !r_done_due;
      x_if   = if_req && idle;
      starve = r_active && d_req && (r_streak >= STARVE_MAX);
      x_ld   = r_active && ld_wvalid && !starve;
      x_d    = d_req && !x_ld;
      x_wl = 1'b0; x_wh = 1'b0; x_addr2 = '0; x_din = '0;
      if (x_ld) begin
        x_addr2 = r_ptr; x_din = ld_wdata; x_wl = 1'b1; x_wh = 1'b1;
      end else if (x_d) begin
        x_addr2 = d_addr;
        if (d_we && d_byte) begin
          x_din = {d_wdata[7:0], d_wdata[7:0]};
          x_wl = (d_addr[0] == 1'b0); x_wh = (d_addr[0] == 1'b1);
        end else if (d_we) begin
          x_din = d_wdata; x_wl = 1'b1; x_wh = 1'b1;
        end
      end
      chk("if_ack", if_ack, x_if);
      chk("d_ack", d_ack, x_d);
      chk("ld_wready", ld_wready, x_ld);
      chk("m_en", m_en, x_if || x_d || x_ld);
      chk("m_we", {m_we_high, m_we_low}, {x_wh, x_wl});
      chk("m_addr1", m_addr1, if_addr);
      if (x_ld || x_d) chk("m_addr2", m_addr2, x_addr2);
      if (x_wl || x_wh) chk("m_data_in", m_data_in, x_din);
      chk("ld_busy", ld_busy, r_active || r_done_due);
      chk("ld_done", ld_done, r_done_due);
      chk("if_rvalid", if_rvalid, e_if_rv);
      if (e_if_rv) chk("if_rdata", if_rdata, e_if_dat);
      chk("d_rvalid", d_rvalid, e_d_rv);
      if (e_d_rv) chk("d_rdata", d_rdata, e_d_dat);
      @(posedge clk);
      e_if_rv = x_if;          e_if_dat = ref_mem[if_addr[15:1]];
      e_d_rv  = x_d && !d_we;  e_d_dat  = ref_mem[d_addr[15:1]];
      if (x_wl) ref_mem[x_addr2[15:1]][7:0]  = x_din[7:0];
      if (x_wh) ref_mem[x_addr2[15:1]][15:8] = x_din[15:8];
      if (!d_req || x_d) r_streak = 0;
      else if (x_ld) r_streak++;
      if (r_done_due) begin
        r_done_due = 1'b0;
      end else if (r_active) begin
        if (x_ld) begin
          r_ptr = r_ptr + 16'd2;
          r_left--;
          if (r_left == 0) begin r_active = 1'b0; r_done_due = 1'b1; end
        end
      end else if (ld_start) begin
        if (ld_count == 16'd0) r_done_due = 1'b1;
        else begin
          r_active = 1'b1; r_left = int'(ld_count); r_ptr = {ld_base[15:1], 1'b0};
        end
      end
    end
    #1;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] e);
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = a;
    step();
    d_req = 1'b0;
    chk(tag, d_rdata, e);
  endtask

  logic [15:0] wrap_exp [3] = '{16'hFFFC, 16'hFFFE, 16'h0000};

  initial begin
    int nw, ng, g1, g2, cyc;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 16'(2 * i);

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Fetch read
    if_req = 1'b1; if_addr = 16'h0104; #1;
    chk("fetch_ack", if_ack, 1'b1);
    step();
    if_req = 1'b0;
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 16'h0104);

    // Byte write to the high byte, then word readback
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'h0201; d_wdata = 16'h00AB; #1;
    chk("bw_we_high", m_we_high, 1'b1);
    chk("bw_we_low", m_we_low, 1'b0);
    chk("bw_data", m_data_in, 16'hABAB);
    step();
    d_we = 1'b0; d_byte = 1'b0;
    do_read("bw_readback", 16'h0200, 16'hAB00);

    // Burst that wraps past 0xFFFE, fetch held off throughout
    ld_start = 1'b1; ld_base = 16'hFFFC; ld_count = 16'd3;
    step();
    ld_start = 1'b0; if_req = 1'b1; if_addr = 16'h0010; ld_wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_wdata = 16'h5A00 + 16'(k); #1;
      chk("wrap_addr", m_addr2, wrap_exp[k]);
      chk("wrap_if_ack", if_ack, 1'b0);
      step();
    end
    ld_wvalid = 1'b0;
    chk("wrap_done", ld_done, 1'b1);
    step();
    chk("wrap_done_clr", ld_done, 1'b0);
    if_req = 1'b0;
    do_read("wrap_w0", 16'hFFFC, 16'h5A00);
    do_read("wrap_w2", 16'h0000, 16'h5A02);

    // Starvation guard over a 10-word burst with data read held pending
    ld_start = 1'b1; ld_base = 16'h1000; ld_count = 16'd10;
    step();
    ld_start = 1'b0; ld_wvalid = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0010;
    nw = 0; ng = 0; g1 = -1; g2 = -1; cyc = 0;
    while (ld_done !== 1'b1 && cyc < 40) begin
      ld_wdata = 16'($urandom); #1;
      if (d_ack) begin
        ng++;
        if (ng == 1) g1 = nw; else if (ng == 2) g2 = nw;
      end
      if (ld_wready) nw++;
      step();
      cyc++;
    end
    ld_wvalid = 1'b0; d_req = 1'b0;
    chk("starve_cycles", cyc, 12);
    chk("starve_grants", ng, 2);
    chk("starve_g1", g1, 4);
    chk("starve_g2", g2, 8);
    chk("starve_words", nw, 10);
    step();

    // Zero-length burst
    ld_start = 1'b1; ld_base = 16'h0500; ld_count = 16'd0;
    step();
    ld_start = 1'b0;
    chk("zero_done", ld_done, 1'b1);
    chk("zero_busy", ld_busy, 1'b1);
    step();
    chk("zero_done_clr", ld_done, 1'b0);

    // Reset in the middle of a 5-word burst
    ld_start = 1'b1; ld_base = 16'h2000; ld_count = 16'd5;
    step();
    ld_start = 1'b0; ld_wvalid = 1'b1;
    ld_wdata = 16'hC0DE; step();
    ld_wdata = 16'hBEEF; step();
    rst_n = 1'b0; #1;
    chk("mid_rst_en", m_en, 1'b0);
    chk("mid_rst_wready", ld_wready, 1'b0);
    chk("mid_rst_busy", ld_busy, 1'b0);
    step(); step();
    ld_wvalid = 1'b0; rst_n = 1'b1;
    step();
    chk("mid_rst_nodone", ld_done, 1'b0);
    do_read("mid_w0", 16'h2000, 16'hC0DE);
    do_read("mid_w1", 16'h2002, 16'hBEEF);
    do_read("mid_w2", 16'h2004, 16'h2004);
    ld_start = 1'b1; ld_base = 16'h3000; ld_count = 16'd1;
    step();
    ld_start = 1'b0;
    chk("restart_busy", ld_busy, 1'b1);
    ld_wvalid = 1'b1; ld_wdata = 16'h1234;
    step();
    ld_wvalid = 1'b0;
    chk("restart_done", ld_done, 1'b1);
    step();
    do_read("restart_w0", 16'h3000, 16'h1234);

    // Randomized traffic in a small address window
    for (int c = 0; c < 800; c++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      if_addr   = 16'h4000 | 16'($urandom_range(0, 255));
      d_req     = ($urandom_range(0, 9) < 6);
      d_we      = ($urandom_range(0, 1) == 1);
      d_byte    = ($urandom_range(0, 1) == 1);
      d_addr    = 16'h4000 | 16'($urandom_range(0, 255));
      d_wdata   = 16'($urandom);
      ld_start  = ($urandom_range(0, 15) == 0);
      ld_base   = 16'h4000 | 16'($urandom_range(0, 255));
      ld_count  = 16'($urandom_range(0, 12));
      ld_wvalid = ($urandom_range(0, 9) < 7);
      ld_wdata  = 16'($urandom);
      step();
    end
    if_req = 1'b0; d_req = 1'b0; ld_start = 1'b0; ld_wvalid = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
